// File: rtl/corr_pkg.sv
// corr_pkg: shared FSM state type and default widths for the gated pulse counter
package corr_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, GATE, LATCH, WAIT_ACK} state_e;
  localparam int CNT_W_DEF  = 12;
  localparam int GATE_W_DEF = 26;
  localparam int GATE_MIN   = 1;
endpackage

// File: rtl/corr_edge_sync.sv
// corr_edge_sync: 2-flop synchroniser plus registered rising-edge detector (3-cycle latency)
module corr_edge_sync (
  input  logic clki,
  input  logic rst,
  input  logic d_async,
  output logic rise_pulse
);
  logic s1_q, s2_q, s3_q, rise_q;
  always_ff @(posedge clki) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      s1_q   <= d_async;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      rise_q <= s2_q & ~s3_q;
    end
  end
  assign rise_pulse = rise_q;
endmodule

// File: rtl/corr_gate_ctrl.sv
// corr_gate_ctrl: counts detector edges over a programmable gate and hands the result off with vld/ack
// Define CORR_SAT_EN for a saturating counter with the ovf flag; otherwise the count wraps.
module corr_gate_ctrl
  import corr_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int GATE_W = GATE_W_DEF
) (
  input  logic              clki,
  input  logic              rst,
  input  logic              start,
  input  logic              cont,
  input  logic [GATE_W-1:0] gate_len,
  input  logic              data_in,
  output logic              busy,
  output logic [CNT_W-1:0]  cnt_val,
  output logic              cnt_vld,
  input  logic              cnt_ack
`ifdef CORR_SAT_EN
  ,
  output logic              ovf
`endif
);
  state_e            state_q, state_d;
  logic [GATE_W-1:0] gate_q, gate_d;
  logic [CNT_W-1:0]  pcnt_q, pcnt_d, val_q, val_d;
  logic              vld_q, vld_d;
  logic              rise;
`ifdef CORR_SAT_EN
  logic              sat_q, sat_d, ovf_q, ovf_d;
  assign ovf = ovf_q;
`endif

  corr_edge_sync u_sync (
    .clki       (clki),
    .rst        (rst),
    .d_async    (data_in),
    .rise_pulse (rise)
  );

  assign busy    = state_q != IDLE;
  assign cnt_val = val_q;
  assign cnt_vld = vld_q;

  always_comb begin
    state_d = state_q;
    gate_d  = gate_q;
    pcnt_d  = pcnt_q;
    val_d   = val_q;
    vld_d   = vld_q;
`ifdef CORR_SAT_EN
    sat_d   = sat_q;
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: state_d = start ? CLEAR : IDLE;
      CLEAR: begin
        pcnt_d  = '0;
        gate_d  = (gate_len == '0) ? GATE_W'(GATE_MIN) : gate_len;
        state_d = GATE;
`ifdef CORR_SAT_EN
        sat_d   = 1'b0;
        ovf_d   = 1'b0;
`endif
      end
      GATE: begin
        gate_d  = gate_q - GATE_W'(1);
        state_d = (gate_q == GATE_W'(GATE_MIN)) ? LATCH : GATE;
`ifdef CORR_SAT_EN
        if (rise) begin
          sat_d  = sat_q | (&pcnt_q);
          pcnt_d = (&pcnt_q) ? pcnt_q : pcnt_q + CNT_W'(1);
        end
`else
        if (rise) pcnt_d = pcnt_q + CNT_W'(1);
`endif
      end
      LATCH: begin
        val_d   = pcnt_q;
        vld_d   = 1'b1;
        state_d = WAIT_ACK;
`ifdef CORR_SAT_EN
        ovf_d   = sat_q;
`endif
      end
      WAIT_ACK: begin
        if (cnt_ack && vld_q) begin
          vld_d   = 1'b0;
          state_d = cont ? CLEAR : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clki) begin
    if (rst) begin
      state_q <= IDLE;
      gate_q  <= '0;
      pcnt_q  <= '0;
      val_q   <= '0;
      vld_q   <= 1'b0;
`ifdef CORR_SAT_EN
      sat_q   <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gate_q  <= gate_d;
      pcnt_q  <= pcnt_d;
      val_q   <= val_d;
      vld_q   <= vld_d;
`ifdef CORR_SAT_EN
      sat_q   <= sat_d;
      ovf_q   <= ovf_d;
`endif
    end
  end
endmodule

// File: tb/tb_corr_gate_ctrl.sv
// tb_corr_gate_ctrl: directed self-checking bench; a second CNT_W=4 instance shares all inputs
module tb_corr_gate_ctrl;
  logic        clki = 1'b0;
  logic        rst = 1'b1, start = 1'b0, cont = 1'b0, data_in = 1'b0, cnt_ack = 1'b0;
  logic [25:0] gate_len = '0;
  logic        busy, cnt_vld, busy4, cnt_vld4;
  logic [11:0] cnt_val;
  logic [3:0]  cnt_val4;
`ifdef CORR_SAT_EN
  logic        ovf, ovf4;
`endif
  int checks = 0;
  int fails = 0;
  int busy_low = 0;

  always #5 clki = ~clki;

  corr_gate_ctrl dut (
    .clki(clki), .rst(rst), .start(start), .cont(cont), .gate_len(gate_len),
    .data_in(data_in), .busy(busy), .cnt_val(cnt_val), .cnt_vld(cnt_vld), .cnt_ack(cnt_ack)
`ifdef CORR_SAT_EN
    , .ovf(ovf)
`endif
  );

  corr_gate_ctrl #(.CNT_W(4)) dut4 (
    .clki(clki), .rst(rst), .start(start), .cont(cont), .gate_len(gate_len),
    .data_in(data_in), .busy(busy4), .cnt_val(cnt_val4), .cnt_vld(cnt_vld4), .cnt_ack(cnt_ack)
`ifdef CORR_SAT_EN
    , .ovf(ovf4)
`endif
  );

  task automatic tick;
    @(posedge clki);
    #1;
  endtask

  // pulses rise every 8 cycles from loop step 4; stops on the first cnt_vld
  task automatic run_gate(input int budget, input int np, output int n, output bit found);
    found = 1'b0;
    n = 0;
    for (int i = 1; i <= budget; i++) begin
      tick();
      n = i;
      if (!busy) busy_low++;
      if (cnt_vld) begin
        found = 1'b1;
        break;
      end
      data_in = (i >= 4 && i < 4 + 8 * np) ? ((i - 4) % 8 < 4) : 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (cnt_vld !== 1'b0) begin fails++; $display("FAIL reset_vld: got %0b expected 0", cnt_vld); end
    checks++; if (cnt_val !== 12'd0) begin fails++; $display("FAIL reset_val: got %0d expected 0", cnt_val); end
`ifdef CORR_SAT_EN
    checks++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %0b expected 0", ovf); end
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single;
    int n;
    bit found;
    gate_len = 26'd100;
    start = 1'b1;
    tick();
    start = 1'b0;
    run_gate(150, 10, n, found);
    checks++; if (found !== 1'b1) begin fails++; $display("FAIL single_found: got %0b expected 1", found); end
    checks++; if (n !== 102) begin fails++; $display("FAIL single_latency: got %0d expected 102", n); end
    checks++; if (cnt_val !== 12'd10) begin fails++; $display("FAIL single_val: got %0d expected 10", cnt_val); end
    repeat (5) tick();
    checks++; if (cnt_vld !== 1'b1) begin fails++; $display("FAIL single_vld_hold: got %0b expected 1", cnt_vld); end
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy_wait: got %0b expected 1", busy); end
    cnt_ack = 1'b1;
    tick();
    cnt_ack = 1'b0;
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy_after_ack: got %0b expected 0", busy); end
    checks++; if (cnt_vld !== 1'b0) begin fails++; $display("FAIL single_vld_after_ack: got %0b expected 0", cnt_vld); end
    checks++; if (cnt_val !== 12'd10) begin fails++; $display("FAIL single_val_hold: got %0d expected 10", cnt_val); end
  endtask

  task automatic test_continuous;
    int n;
    bit found;
    gate_len = 26'd50;
    cont = 1'b1;
    busy_low = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 0; r < 3; r++) begin
      run_gate(80, r + 2, n, found);
      checks++; if (found !== 1'b1) begin fails++; $display("FAIL cont_found round %0d: got %0b expected 1", r, found); end
      checks++; if (n !== 52) begin fails++; $display("FAIL cont_latency round %0d: got %0d expected 52", r, n); end
      checks++; if (cnt_val !== 12'(r + 2)) begin fails++; $display("FAIL cont_val round %0d: got %0d expected %0d", r, cnt_val, r + 2); end
      tick();
      checks++; if (cnt_vld !== 1'b1) begin fails++; $display("FAIL cont_vld_second round %0d: got %0b expected 1", r, cnt_vld); end
      if (r == 2) cont = 1'b0;
      cnt_ack = 1'b1;
      tick();
      cnt_ack = 1'b0;
      checks++; if (cnt_vld !== 1'b0) begin fails++; $display("FAIL cont_vld_clear round %0d: got %0b expected 0", r, cnt_vld); end
      if (r < 2) begin
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL cont_busy_after_ack round %0d: got %0b expected 1", r, busy); end
      end
    end
    checks++; if (busy_low !== 0) begin fails++; $display("FAIL cont_busy_never_low: got %0d low cycles expected 0", busy_low); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL cont_final_idle: got %0b expected 0", busy); end
  endtask

  task automatic test_zero_gate;
    int n;
    bit found;
    gate_len = 26'd0;
    data_in = 1'b1;
    repeat (2) tick();
    data_in = 1'b0;
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    run_gate(10, 0, n, found);
    checks++; if (found !== 1'b1) begin fails++; $display("FAIL zero_found: got %0b expected 1", found); end
    checks++; if (n !== 3) begin fails++; $display("FAIL zero_gate_len: got %0d expected 3", n); end
    checks++; if (cnt_val !== 12'd0) begin fails++; $display("FAIL zero_val: got %0d expected 0", cnt_val); end
    cnt_ack = 1'b1;
    tick();
    cnt_ack = 1'b0;
  endtask

  task automatic test_overflow;
    int n;
    bit found;
    gate_len = 26'd200;
    start = 1'b1;
    tick();
    start = 1'b0;
    run_gate(250, 20, n, found);
    checks++; if (n !== 202) begin fails++; $display("FAIL ovf_latency: got %0d expected 202", n); end
    checks++; if (cnt_val !== 12'd20) begin fails++; $display("FAIL ovf_val12: got %0d expected 20", cnt_val); end
    checks++; if (cnt_vld4 !== 1'b1) begin fails++; $display("FAIL ovf_vld4: got %0b expected 1", cnt_vld4); end
`ifdef CORR_SAT_EN
    checks++; if (cnt_val4 !== 4'd15) begin fails++; $display("FAIL ovf_val4: got %0d expected 15", cnt_val4); end
    checks++; if (ovf4 !== 1'b1) begin fails++; $display("FAIL ovf_flag4: got %0b expected 1", ovf4); end
    checks++; if (ovf !== 1'b0) begin fails++; $display("FAIL ovf_flag12: got %0b expected 0", ovf); end
`else
    checks++; if (cnt_val4 !== 4'd4) begin fails++; $display("FAIL ovf_wrap4: got %0d expected 4", cnt_val4); end
`endif
    cnt_ack = 1'b1;
    tick();
    cnt_ack = 1'b0;
  endtask

  task automatic test_reset_mid_gate;
    int n;
    bit found;
    int vld_seen = 0;
    int busy_seen = 0;
    gate_len = 26'd100;
    start = 1'b1;
    tick();
    start = 1'b0;
    run_gate(30, 10, n, found);
    checks++; if (found !== 1'b0) begin fails++; $display("FAIL midrst_early_vld: got %0b expected 0", found); end
    rst = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %0b expected 0", busy); end
    checks++; if (cnt_val !== 12'd0) begin fails++; $display("FAIL midrst_val: got %0d expected 0", cnt_val); end
    checks++; if (cnt_val4 !== 4'd0) begin fails++; $display("FAIL midrst_val4: got %0d expected 0", cnt_val4); end
    checks++; if (cnt_vld !== 1'b0) begin fails++; $display("FAIL midrst_vld: got %0b expected 0", cnt_vld); end
`ifdef CORR_SAT_EN
    checks++; if (ovf4 !== 1'b0) begin fails++; $display("FAIL midrst_ovf4: got %0b expected 0", ovf4); end
`endif
    rst = 1'b0;
    data_in = 1'b0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (cnt_vld) vld_seen++;
      if (busy) busy_seen++;
    end
    checks++; if (vld_seen !== 0) begin fails++; $display("FAIL midrst_no_vld: got %0d vld cycles expected 0", vld_seen); end
    checks++; if (busy_seen !== 0) begin fails++; $display("FAIL midrst_stays_idle: got %0d busy cycles expected 0", busy_seen); end
  endtask

  task automatic test_start_held;
    int n;
    bit found;
    int busy_seen = 0;
    gate_len = 26'd20;
    start = 1'b1;
    tick();
    run_gate(40, 2, n, found);
    checks++; if (cnt_val !== 12'd2) begin fails++; $display("FAIL held_val: got %0d expected 2", cnt_val); end
    checks++; if (n !== 22) begin fails++; $display("FAIL held_latency: got %0d expected 22", n); end
    tick();
    cnt_ack = 1'b1;
    start = 1'b0;
    tick();
    cnt_ack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (busy) busy_seen++;
      tick();
    end
    checks++; if (busy_seen !== 0) begin fails++; $display("FAIL held_no_rerun: got %0d busy cycles expected 0", busy_seen); end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL held_new_run: got %0b expected 1", busy); end
    run_gate(40, 1, n, found);
    checks++; if (cnt_val !== 12'd1) begin fails++; $display("FAIL held_second_val: got %0d expected 1", cnt_val); end
    cnt_ack = 1'b1;
    tick();
    cnt_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_continuous();
    test_zero_gate();
    test_overflow();
    test_reset_mid_gate();
    test_start_held();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/corr_gate_ctrl.md
CORR_GATE_CTRL -- requirements
Module: corr_gate_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 12, setting the count result width.
REQ-002 The block SHALL have parameter GATE_W, default 26, setting the gate-length width.
REQ-003 The block SHALL have port clki, input, 1, the single system clock (100 MHz); all logic SHALL be clocked on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, a synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1, a request to begin an acquisition; it SHALL be honoured only in IDLE.
REQ-006 The block SHALL have port cont, input, 1, selecting continuous mode; it SHALL be sampled only at the ack cycle.
REQ-007 The block SHALL have port gate_len, input, GATE_W, giving the gate length in clki cycles; it SHALL be sampled only in CLEAR.
REQ-008 The block SHALL have port data_in, input, 1, the asynchronous detector pulse line.
REQ-009 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-010 The block SHALL have port cnt_val, output, CNT_W, holding the latched gate count.
REQ-011 The block SHALL have port cnt_vld, output, 1, indicating that cnt_val is valid.
REQ-012 The block SHALL have port cnt_ack, input, 1, the consumer acknowledge.
REQ-013 The block SHALL have port ovf, output, 1, the saturation flag; it SHALL be present only when CORR_SAT_EN is defined.

Function
REQ-014 The FSM SHALL have the states IDLE, CLEAR, GATE, LATCH and WAIT_ACK.
REQ-015 From IDLE, start=1 SHALL move the FSM to CLEAR; otherwise it SHALL remain in IDLE.
REQ-016 CLEAR SHALL last 1 cycle, zero the pulse counter, load the gate counter with gate_len (0 treated as 1), and move to GATE.
REQ-017 GATE SHALL last exactly the loaded number of cycles, decrementing the gate counter by one each cycle, and SHALL move to LATCH on the cycle the gate counter equals 1.
REQ-018 data_in SHALL pass through a 2-flop synchroniser followed by a rising-edge detector; each 1-cycle edge pulse SHALL increment the pulse counter only while the state is GATE.
REQ-019 The latency from a data_in rising edge to the edge pulse SHALL be 3 clki cycles; edge pulses falling outside GATE SHALL be discarded.
REQ-020 LATCH SHALL last 1 cycle, copy the pulse counter to cnt_val, set cnt_vld=1 from the next cycle, and move to WAIT_ACK.
REQ-021 In WAIT_ACK, cnt_ack=1 while cnt_vld=1 SHALL clear cnt_vld on the next cycle, and the FSM SHALL go to CLEAR if cont=1, else to IDLE.
REQ-022 cnt_ack while cnt_vld=0 SHALL be ignored.
REQ-023 cnt_val SHALL hold its value until the next LATCH.
REQ-024 start outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-025 Without CORR_SAT_EN, the pulse counter SHALL wrap modulo 2^CNT_W.

Reset
REQ-026 rst=1 SHALL, at the next clki edge from any state, force IDLE and set busy=0, cnt_vld=0, cnt_val=0, ovf=0, both counters to 0 and the synchroniser flops to 0.
REQ-027 Reset mid-gate SHALL discard the partial count, and no cnt_vld SHALL follow.

Configuration
REQ-028 With CORR_SAT_EN defined, the pulse counter SHALL saturate at 2^CNT_W-1, and ovf SHALL be latched in LATCH alongside cnt_val, set if any edge arrived while the counter was saturated, and cleared in CLEAR.
REQ-029 Without CORR_SAT_EN, the ovf port and the saturation logic SHALL be absent and the counter SHALL wrap.

Structure
REQ-030 Package corr_pkg SHALL hold the FSM state enum, default CNT_W and GATE_W constants, and the gate-length minimum of 1.
REQ-031 The synchroniser and edge detector SHALL be sub-module corr_edge_sync (ports clki, rst, d_async, rise_pulse).
REQ-032 The FSM and counters SHALL reside in corr_gate_ctrl.

Verification
REQ-033 The bench SHALL cover: gate_len=100, 10 data_in pulses spaced 8 cycles inside the gate, start pulsed -> cnt_val=10, cnt_vld high until ack, busy low 1 cycle after ack with cont=0.
REQ-034 The bench SHALL cover: cont=1, gate_len=50, ack on the second cycle of each cnt_vld -> CLEAR follows ack, three consecutive results, and busy never deasserts.
REQ-035 The bench SHALL cover: gate_len=0, one pulse 5 cycles before start -> a single 1-cycle gate and cnt_val=0.
REQ-036 The bench SHALL cover: CNT_W=4, gate_len=200, 20 pulses -> cnt_val=4 (wrap) without the macro, or cnt_val=15 and ovf=1 with CORR_SAT_EN.
REQ-037 The bench SHALL cover: rst asserted at gate cycle 30 of 100 with pulses active -> IDLE next cycle, all outputs 0, and no cnt_vld afterwards.
REQ-038 The bench SHALL cover: start held high during GATE and WAIT_ACK with cont=0 -> no second run after ack, and a new run only when start is seen in IDLE.
